// File: rtl/fetch_pcgen.sv
// -----------------------------------------------------------------------------
// fetch_pcgen
//
// PC-generation stage of the instruction front end. Owns the architectural
// fetch PC, exchanges it with the branch predictor for the next PC and the
// valid-word mask, and queues each accepted fetch group {pc, validword} in a
// small FIFO that is presented to the instruction cache over valid/ready.
//
// Ports:
//   clk_i            clock, rising edge
//   rst_n_i          synchronous active-low reset
//   flush_i          pipeline flush; redirects the PC to flush_newpc_i
//   flush_newpc_i    redirect target, valid with flush_i
//   bpu_busy_i       predictor table update in progress; hold the PC
//   bpu_pc_next_i    predicted next fetch PC
//   bpu_validword_i  valid-word mask for the current group
//   pc_o             current fetch PC, to the predictor
//   pcgen_ready_o    this cycle's group is accepted and the PC advances
//   req_valid_o      FIFO head valid toward the icache
//   req_ready_i      icache accepts the head
//   req_pc_o         head PC (0 when the FIFO is empty)
//   req_validword_o  head valid-word mask (0 when the FIFO is empty)
//
// Optional feature (macro PCGEN_PERF_CNT_EN):
//   perf_group_cnt_o  64-bit count of pushed fetch groups
//   perf_stall_cnt_o  64-bit count of RUN/STALL cycles without an advance
//                     (flush cycles excluded)
// -----------------------------------------------------------------------------
module fetch_pcgen #(
    parameter int unsigned    XLEN         = 64,
    parameter logic [XLEN-1:0] RESET_VECTOR = 64'h0000_0000_8000_0000,
    parameter int unsigned    FIFO_DEPTH   = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] flush_newpc_i,
    input  logic            bpu_busy_i,
    input  logic [XLEN-1:0] bpu_pc_next_i,
    input  logic [3:0]      bpu_validword_i,
    output logic [XLEN-1:0] pc_o,
    output logic            pcgen_ready_o,
    output logic            req_valid_o,
    input  logic            req_ready_i,
    output logic [XLEN-1:0] req_pc_o,
    output logic [3:0]      req_validword_o
`ifdef PCGEN_PERF_CNT_EN
    ,
    output logic [63:0]     perf_group_cnt_o,
    output logic [63:0]     perf_stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN,
        ST_STALL
    } state_t;

    state_t            state;
    logic [XLEN-1:0]   pc_q;

    logic [XLEN-1:0]   pc_mem [FIFO_DEPTH];
    logic [3:0]        vw_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;

    logic              push;
    logic              pop;

    // Acceptance looks at the occupancy before any same-cycle pop, so a full
    // FIFO never takes a push even while the icache is draining it.
    assign pcgen_ready_o = (state == ST_RUN) & ~bpu_busy_i & ~flush_i &
                           (count < CNT_W'(FIFO_DEPTH));
    assign push          = pcgen_ready_o;
    assign req_valid_o   = (count != '0);
    assign pop           = req_valid_o & req_ready_i;

    assign pc_o            = pc_q;
    assign req_pc_o        = req_valid_o ? pc_mem[rd_ptr] : '0;
    assign req_validword_o = req_valid_o ? vw_mem[rd_ptr] : '0;

    // Control state: FSM, fetch PC, FIFO pointers and occupancy.
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= ST_BOOT;
            pc_q   <= RESET_VECTOR;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            // Flush wins over busy and any handshake: a beat the icache
            // accepted this cycle is killed along with the rest of the queue.
            state  <= ST_RUN;
            pc_q   <= flush_newpc_i;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            case (state)
                ST_BOOT:  state <= ST_RUN;
                ST_RUN:   if (bpu_busy_i) state <= ST_STALL;
                ST_STALL: if (!bpu_busy_i) state <= ST_RUN;
                default:  state <= ST_BOOT;
            endcase

            if (push) begin
                pc_q   <= bpu_pc_next_i;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage.
    // NOTE: the entry array has no reset; validity is tracked entirely by the
    // pointers and count, and the head outputs are masked while empty.
    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[wr_ptr] <= pc_q;
            vw_mem[wr_ptr] <= bpu_validword_i;
        end
    end

`ifdef PCGEN_PERF_CNT_EN
    // Stall cycles: fetch is live (not booting) but no group was accepted,
    // and the cycle is not a redirect. Counters survive flushes.
    logic stall_cycle;
    assign stall_cycle = (state != ST_BOOT) & ~pcgen_ready_o & ~flush_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            perf_group_cnt_o <= '0;
            perf_stall_cnt_o <= '0;
        end else begin
            if (push) begin
                perf_group_cnt_o <= perf_group_cnt_o + 64'd1;
            end
            if (stall_cycle) begin
                perf_stall_cnt_o <= perf_stall_cnt_o + 64'd1;
            end
        end
    end
`endif

endmodule
